alu: RTL and testbench
======================

Name: alu

Overview:
- 32-bit two's-complement arithmetic/logic unit for the CPU datapath, with registered outputs.
- Computes a result from operands a, b and the opcode op.
- Produces ARM-style condition flags {N, Z, C, V} for the branch/compare logic.
- Result and flags are captured on the rising clock edge (1-cycle latency).

Parameters:
- None. Data width fixed at 32, opcode width fixed at 4.

Ports:
- clk    input   1   system clock, rising-edge active
- rst_n  input   1   asynchronous, active-low reset
- a      input   32  operand A (signed two's complement)
- b      input   32  operand B (signed two's complement)
- op     input   4   operation select
- res    output  32  registered result
- flags  output  4   registered flags {N, Z, C, V}: flags[3]=N, flags[2]=Z, flags[1]=C, flags[0]=V

Behaviour:
- Reset: while rst_n=0, res=0 and flags=4'b0000, applied immediately (asynchronous). The first capture occurs on the first rising clk after rst_n deasserts.
- Each rising clk, res and flags take the combinational result of the current a, b, op. Latency is exactly 1 cycle; a new op is accepted every cycle; there is no handshake.
- Opcodes:
  - 0 ADD: a+b
  - 1 SUB: a+~b+1
  - 2 AND
  - 3 OR
  - 4 XOR
  - 5 SLL: a << b[4:0]
  - 6 SRL: logical a >> b[4:0]
  - 7 SRA: arithmetic a >>> b[4:0]
  - 8 SLT: res = (signed a < signed b) ? 1 : 0
  - 9 SLTU: unsigned compare, same encoding as SLT
  - 10 MUL: only with ALU_MUL_EN, see Optional Feature
  - 11-15: res=0
- N = res[31]; Z = (res==0). These apply for every op, including undefined ones.
- C for ADD: carry-out of the 33-bit sum.
- C for SUB: carry-out of a+~b+1. C=1 means no borrow (a >= b unsigned).
- V for ADD: a and b have the same sign and res has a different sign.
- V for SUB: a and b have different signs and res sign differs from a.
- For SUB, the N, Z, C, V flags are also computed (internally) for SLT. SLT = N xor V. SLTU = ~C.
- All ops other than ADD/SUB: C=0, V=0.
- Wrap-around: results are truncated to 32 bits. Overflow does not saturate.
- Shift amount of 0 returns a unchanged. b[31:5] is ignored for shifts.
- A change on a, b or op between edges has no effect on the outputs until the next edge.
- Reset asserted mid-stream clears the outputs immediately. No pending result survives reset.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: op 10 = MUL, res = low 32 bits of a*b (signed and unsigned give the same low half). N and Z are from res; C=0, V=0. Still 1-cycle latency.
- Undefined: op 10 behaves as an undefined opcode (res=0, flags=4'b0100). No multiplier is inferred.

Test Plan:
- SUB a=0, b=0 -> res=0, flags=4'b0110. SUB a=11, b=11 -> flags=4'b0110.
- SUB a=2, b=3 -> res=-1, flags=4'b1000. SUB a=-32, b=7 -> res=-39, flags=4'b1010. SUB a=-32, b=33 -> res=-65, flags=4'b1010.
- SUB a=8, b=-7 -> res=15, flags=4'b0000. SUB a=0xFFFFFFFF, b=5 -> flags=4'b1010.
- SUB a=0x8000000A, b=11 -> res=0x7FFFFFFF, flags=4'b0011. SUB a=0x80000000, b=2 -> flags=4'b0011.
- ADD a=0x7FFFFFFF, b=1 -> res=0x80000000, flags=4'b1001. ADD a=0xFFFFFFFF, b=1 -> res=0, flags=4'b0110. SRA a=0x80000000, b=4 -> res=0xF8000000, flags=4'b1000.
- Reset and latency:
  - Assert rst_n=0 mid-stream -> res=0, flags=0 without a clock edge.
  - After release, apply SLT a=-1, b=1 -> res=1 one cycle later, and not before that edge.

Source files
------------

// File: rtl/alu.sv
// 32-bit ALU with registered result and {N,Z,C,V} flags, one-cycle latency.
// Define ALU_MUL_EN to enable op 10 (MUL, low 32 bits of a*b).
module alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] res,
    output logic [3:0]  flags
);
    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'd10;
`endif

    // One shared adder: anything but ADD runs as a+~b+1, so SLT/SLTU reuse SUB flags.
    logic        sub;
    logic [31:0] bx;
    logic [32:0] sum;
    logic        cout;
    logic        ovf;
    logic        lt_s;
    logic        lt_u;

    assign sub  = (op != OP_ADD);
    assign bx   = sub ? ~b : b;
    assign sum  = {1'b0, a} + {1'b0, bx} + {32'd0, sub};
    assign cout = sum[32];
    // Overflow when the effective operands share a sign and the result flips it.
    assign ovf  = (a[31] == bx[31]) && (sum[31] != a[31]);
    assign lt_s = sum[31] ^ ovf;
    assign lt_u = ~cout;

    logic [31:0] r;
    logic        c;
    logic        v;

    always_comb begin
        r = 32'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                r = sum[31:0];
                c = cout;
                v = ovf;
            end
            OP_AND:  r = a & b;
            OP_OR:   r = a | b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << b[4:0];
            OP_SRL:  r = a >> b[4:0];
            OP_SRA:  r = $signed(a) >>> b[4:0];
            OP_SLT:  r = {31'd0, lt_s};
            OP_SLTU: r = {31'd0, lt_u};
`ifdef ALU_MUL_EN
            OP_MUL:  r = a * b;
`endif
            default: r = 32'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res   <= 32'd0;
            flags <= 4'b0000;
        end else begin
            res   <= r;
            flags <= {r[31], (r == 32'd0), c, v};
        end
    end
endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed table, randomized ops against a
// plain-arithmetic reference model, hold between edges, async reset, latency.
module tb_alu;
    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic [31:0] res;
    logic [3:0]  flags;

    int vectors = 0;
    int miscompares = 0;

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .op    (op),
        .res   (res),
        .flags (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic [3:0]  f;
    } vec_t;

    // Reference model straight from the arithmetic definitions.
    function automatic void model(input logic [31:0] ia, input logic [31:0] ib,
                                  input logic [3:0] iop,
                                  output logic [31:0] r, output logic [3:0] f);
        longint sa, sb, ss;
        longint unsigned us;
        logic c, v;
        sa = longint'($signed(ia));
        sb = longint'($signed(ib));
        c = 1'b0;
        v = 1'b0;
        r = 32'd0;
        case (iop)
            4'd0: begin
                us = longint'(ia) + longint'(ib);
                r = us[31:0];
                c = us[32];
                ss = sa + sb;
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd1: begin
                r = ia - ib;
                c = (ia >= ib);
                ss = sa - sb;
                v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
            end
            4'd2: r = ia & ib;
            4'd3: r = ia | ib;
            4'd4: r = ia ^ ib;
            4'd5: r = ia << ib[4:0];
            4'd6: r = ia >> ib[4:0];
            4'd7: begin
                ss = sa >>> ib[4:0];
                r = ss[31:0];
            end
            4'd8: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd9: r = (ia < ib) ? 32'd1 : 32'd0;
`ifdef ALU_MUL_EN
            4'd10: r = ia * ib;
`endif
            default: r = 32'd0;
        endcase
        f = {r[31], (r == 32'd0), c, v};
    endfunction

    task automatic drive(input logic [31:0] ia, input logic [31:0] ib, input logic [3:0] iop);
        @(negedge clk);
        a = ia;
        b = ib;
        op = iop;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        a = 32'hDEADBEEF;
        b = 32'h1;
        op = 4'd0;
        #2;
        vectors++;
        if (res !== 32'd0 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_state: res=%h flags=%b, want res=0 flags=0000", res, flags);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t tbl[$];
        tbl.push_back({4'd1, 32'h0,        32'h0,        32'h0,        4'b0110});
        tbl.push_back({4'd1, 32'd11,       32'd11,       32'h0,        4'b0110});
        tbl.push_back({4'd1, 32'd2,        32'd3,        32'hFFFFFFFF, 4'b1000});
        tbl.push_back({4'd1, 32'hFFFFFFE0, 32'd7,        32'hFFFFFFD9, 4'b1010});
        tbl.push_back({4'd1, 32'hFFFFFFE0, 32'd33,       32'hFFFFFFBF, 4'b1010});
        tbl.push_back({4'd1, 32'd8,        32'hFFFFFFF9, 32'd15,       4'b0000});
        tbl.push_back({4'd1, 32'hFFFFFFFF, 32'd5,        32'hFFFFFFFA, 4'b1010});
        tbl.push_back({4'd1, 32'h8000000A, 32'd11,       32'h7FFFFFFF, 4'b0011});
        tbl.push_back({4'd1, 32'h80000000, 32'd2,        32'h7FFFFFFE, 4'b0011});
        tbl.push_back({4'd0, 32'h7FFFFFFF, 32'd1,        32'h80000000, 4'b1001});
        tbl.push_back({4'd0, 32'hFFFFFFFF, 32'd1,        32'h0,        4'b0110});
        tbl.push_back({4'd7, 32'h80000000, 32'd4,        32'hF8000000, 4'b1000});
        tbl.push_back({4'd5, 32'h12345678, 32'hFFFFFFE0, 32'h12345678, 4'b0000});
        tbl.push_back({4'd6, 32'h80000000, 32'd31,       32'h1,        4'b0000});
        tbl.push_back({4'd8, 32'hFFFFFFFF, 32'd1,        32'h1,        4'b0000});
        tbl.push_back({4'd9, 32'h1,        32'hFFFFFFFF, 32'h1,        4'b0000});
        tbl.push_back({4'd9, 32'hFFFFFFFF, 32'h1,        32'h0,        4'b0100});
        tbl.push_back({4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,       4'b0100});
`ifdef ALU_MUL_EN
        tbl.push_back({4'd10, 32'd3,       32'hFFFFFFFE, 32'hFFFFFFFA, 4'b1000});
`else
        tbl.push_back({4'd10, 32'd3,       32'hFFFFFFFE, 32'h0,        4'b0100});
`endif
        foreach (tbl[i]) begin
            drive(tbl[i].a, tbl[i].b, tbl[i].op);
            @(posedge clk);
            #1;
            vectors++;
            if (res !== tbl[i].r || flags !== tbl[i].f) begin
                miscompares++;
                $display("FAIL directed[%0d] op=%0d a=%h b=%h: res=%h flags=%b, want res=%h flags=%b",
                         i, tbl[i].op, tbl[i].a, tbl[i].b, res, flags, tbl[i].r, tbl[i].f);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] ra, rb, er;
        logic [3:0]  rop, ef;
        for (int i = 0; i < 400; i++) begin
            ra = $urandom;
            rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h80000000 ^ 32'($urandom_range(0, 1));
            rop = 4'($urandom_range(0, 15));
            model(ra, rb, rop, er, ef);
            drive(ra, rb, rop);
            @(posedge clk);
            #1;
            vectors++;
            if (res !== er || flags !== ef) begin
                miscompares++;
                $display("FAIL random[%0d] op=%0d a=%h b=%h: res=%h flags=%b, want res=%h flags=%b",
                         i, rop, ra, rb, res, flags, er, ef);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] er;
        logic [3:0]  ef;
        model(32'd100, 32'd58, 4'd1, er, ef);
        drive(32'd100, 32'd58, 4'd1);
        @(posedge clk);
        #1;
        a = 32'hFFFFFFFF;
        b = 32'd1;
        op = 4'd0;
        #3;
        vectors++;
        if (res !== er || flags !== ef) begin
            miscompares++;
            $display("FAIL hold_between_edges: res=%h flags=%b, want res=%h flags=%b", res, flags, er, ef);
        end
    endtask

    task automatic test_reset_midstream();
        drive(32'h7FFFFFFF, 32'd1, 4'd0);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (res !== 32'd0 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_midstream: res=%h flags=%b, want res=0 flags=0000", res, flags);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (res !== 32'd0 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_held_edge: res=%h flags=%b, want res=0 flags=0000", res, flags);
        end
    endtask

    task automatic test_latency();
        @(negedge clk);
        rst_n = 1'b1;
        a = 32'hFFFFFFFF;
        b = 32'd1;
        op = 4'd8;
        #3;
        vectors++;
        if (res !== 32'd0 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL latency_before_edge: res=%h flags=%b, want res=0 flags=0000", res, flags);
        end
        @(posedge clk);
        #1;
        vectors++;
        if (res !== 32'd1 || flags !== 4'b0000) begin
            miscompares++;
            $display("FAIL latency_after_edge: res=%h flags=%b, want res=1 flags=0000", res, flags);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_hold();
        test_reset_midstream();
        test_latency();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
